kv_cache_controller: RTL and testbench

- Key/value storage engine directly downstream of obi_cache_interface.
- Consumes the decoded operation, key and value the interface holds stable during its processing state.
- Runs a fixed-latency sequential search over NUM_ENTRIES slots and commits the operation.
- Returns ready, success and read value to the interface's ready_in, op_succ_in and value_in inputs.

---
 rtl/ctrl_types_pkg.sv | 16 +
 rtl/if_types_pkg.sv | 6 +
 rtl/kv_entry_store.sv | 58 +++++
 rtl/kv_cache_controller.sv | 165 ++++++++++++++++
 tb/tb_kv_cache_controller.sv | 134 +++++++++++++
 5 files changed

// File: rtl/ctrl_types_pkg.sv
// Operation and FSM state encodings used by the key/value cache controller.
package ctrl_types_pkg;
   typedef enum logic [if_types_pkg::OP_WIDTH-1:0] {
      NOOP   = 2'd0,
      READ   = 2'd1,
      UPSERT = 2'd2,
      DELETE = 2'd3
   } operation_e;

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_SEARCH   = 2'd1,
      ST_RESPOND  = 2'd2,
      ST_WAIT_CLR = 2'd3
   } ctrl_state_e;
endpackage

// File: rtl/if_types_pkg.sv
// Shared widths of the decoded request handed over by obi_cache_interface.
package if_types_pkg;
   localparam int OP_WIDTH    = 2;
   localparam int KEY_WIDTH   = 32;
   localparam int VALUE_WIDTH = 32;
endpackage

// File: rtl/kv_entry_store.sv
// Valid/key/value slot arrays with one combinational read port, one write/clear
// port and a running count of valid slots.
module kv_entry_store #(
   parameter int NUM_ENTRIES = 8,
   parameter int KEY_WIDTH   = 32,
   parameter int VALUE_WIDTH = 32,
   localparam int IDX_W      = $clog2(NUM_ENTRIES),
   localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic [IDX_W-1:0]       rd_idx,
   output logic                   rd_valid,
   output logic [KEY_WIDTH-1:0]   rd_key,
   output logic [VALUE_WIDTH-1:0] rd_value,
   input  logic                   wr_en,
   input  logic                   clr_en,
   input  logic [IDX_W-1:0]       wr_idx,
   input  logic [KEY_WIDTH-1:0]   wr_key,
   input  logic [VALUE_WIDTH-1:0] wr_value,
   output logic [CNT_W-1:0]       count
);
   logic [NUM_ENTRIES-1:0] valid_r;
   logic [KEY_WIDTH-1:0]   key_r   [NUM_ENTRIES];
   logic [VALUE_WIDTH-1:0] value_r [NUM_ENTRIES];
   logic [CNT_W-1:0]       count_r;

   assign rd_valid = valid_r[rd_idx];
   assign rd_key   = key_r[rd_idx];
   assign rd_value = value_r[rd_idx];
   assign count    = count_r;

   // Valid bits and occupancy count; count only moves when a slot changes state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_r <= '0;
         count_r <= '0;
      end else if (wr_en) begin
         valid_r[wr_idx] <= 1'b1;
         if (!valid_r[wr_idx]) begin
            count_r <= count_r + CNT_W'(1);
         end
      end else if (clr_en) begin
         valid_r[wr_idx] <= 1'b0;
         if (valid_r[wr_idx]) begin
            count_r <= count_r - CNT_W'(1);
         end
      end
   end

   // Key/value payload needs no reset; it is qualified by the valid bits.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         key_r[wr_idx]   <= wr_key;
         value_r[wr_idx] <= wr_value;
      end
   end
endmodule

// File: rtl/kv_cache_controller.sv
// Fixed-latency key/value engine: sequential search over all slots, commit on
// the last search edge, registered one-cycle ready pulse, then wait for NOOP.
module kv_cache_controller
   import ctrl_types_pkg::*;
#(
   parameter int NUM_ENTRIES = 8,
   parameter int KEY_WIDTH   = if_types_pkg::KEY_WIDTH,
   parameter int VALUE_WIDTH = if_types_pkg::VALUE_WIDTH,
   localparam int IDX_W      = $clog2(NUM_ENTRIES),
   localparam int CNT_W      = $clog2(NUM_ENTRIES + 1)
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  operation_e             operation_in,
   input  logic [KEY_WIDTH-1:0]   key_in,
   input  logic [VALUE_WIDTH-1:0] value_in,
   output logic                   ready_out,
   output logic                   op_succ_out,
   output logic [VALUE_WIDTH-1:0] value_out,
   output logic [CNT_W-1:0]       count_out
);
   ctrl_state_e            state_r, state_s;
   logic [IDX_W-1:0]       idx_r;
   logic                   hit_r, hit_s, match_s;
   logic [IDX_W-1:0]       hit_idx_r, hit_idx_s;
   logic [VALUE_WIDTH-1:0] hit_value_r, hit_value_s;
   logic                   free_found_r, free_found_s;
   logic [IDX_W-1:0]       free_idx_r, free_idx_s;
   logic                   last_s, commit_s, accept_s;
   logic                   ready_r, op_succ_r, succ_s;
   logic [VALUE_WIDTH-1:0] value_r, result_s;
   logic                   rd_valid_s, wr_en_s, clr_en_s;
   logic [KEY_WIDTH-1:0]   rd_key_s;
   logic [VALUE_WIDTH-1:0] rd_value_s;
   logic [IDX_W-1:0]       wr_idx_s;

   kv_entry_store #(
      .NUM_ENTRIES (NUM_ENTRIES),
      .KEY_WIDTH   (KEY_WIDTH),
      .VALUE_WIDTH (VALUE_WIDTH)
   ) u_store (
      .clk      (clk),
      .rst_n    (rst_n),
      .rd_idx   (idx_r),
      .rd_valid (rd_valid_s),
      .rd_key   (rd_key_s),
      .rd_value (rd_value_s),
      .wr_en    (wr_en_s),
      .clr_en   (clr_en_s),
      .wr_idx   (wr_idx_s),
      .wr_key   (key_in),
      .wr_value (value_in),
      .count    (count_out)
   );

   assign ready_out   = ready_r;
   assign op_succ_out = op_succ_r;
   assign value_out   = value_r;

   // Next-state logic.
   always_comb begin
      state_s = state_r;
      case (state_r)
         ST_IDLE:     if (operation_in != NOOP) state_s = ST_SEARCH; else state_s = ST_IDLE;
         ST_SEARCH:   if (last_s) state_s = ST_RESPOND; else state_s = ST_SEARCH;
         ST_RESPOND:  state_s = ST_WAIT_CLR;
         ST_WAIT_CLR: if (operation_in == NOOP) state_s = ST_IDLE; else state_s = ST_WAIT_CLR;
         default:     state_s = ST_IDLE;
      endcase
   end

   // Search step: fold the slot under idx into the running hit / lowest-free result.
   always_comb begin
      last_s       = (idx_r == IDX_W'(NUM_ENTRIES - 1));
      accept_s     = (state_r == ST_IDLE) && (state_s == ST_SEARCH);
      commit_s     = (state_r == ST_SEARCH) && last_s;
      match_s      = rd_valid_s && (rd_key_s == key_in);
      hit_s        = hit_r | match_s;
      hit_idx_s    = match_s ? idx_r : hit_idx_r;
      hit_value_s  = match_s ? rd_value_s : hit_value_r;
      free_found_s = free_found_r | !rd_valid_s;
      free_idx_s   = free_found_r ? free_idx_r : idx_r;
   end

   // Commit decision; the only slot ever written or cleared is hit_idx or free_idx.
   always_comb begin
      wr_en_s  = 1'b0;
      clr_en_s = 1'b0;
      succ_s   = 1'b0;
      result_s = '0;
      wr_idx_s = hit_s ? hit_idx_s : free_idx_s;
      if (commit_s) begin
         case (operation_in)
            READ: begin
               if (hit_s) begin
                  succ_s   = 1'b1;
                  result_s = hit_value_s;
               end else begin
                  succ_s   = 1'b0;
               end
            end
            UPSERT: begin
               result_s = value_in;
               if (hit_s || free_found_s) begin
                  wr_en_s = 1'b1;
                  succ_s  = 1'b1;
               end else begin
                  succ_s  = 1'b0;
               end
            end
            DELETE: begin
               if (hit_s) begin
                  clr_en_s = 1'b1;
                  succ_s   = 1'b1;
                  result_s = hit_value_s;
               end else begin
                  succ_s   = 1'b0;
               end
            end
            default: begin
               succ_s = 1'b0;
            end
         endcase
      end else begin
         succ_s = 1'b0;
      end
   end

   // State, search registers and held result; ready lags RESPOND by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r      <= ST_IDLE;
         idx_r        <= '0;
         hit_r        <= 1'b0;
         hit_idx_r    <= '0;
         hit_value_r  <= '0;
         free_found_r <= 1'b0;
         free_idx_r   <= '0;
         ready_r      <= 1'b0;
         op_succ_r    <= 1'b0;
         value_r      <= '0;
      end else begin
         state_r <= state_s;
         ready_r <= (state_r == ST_RESPOND);
         if (accept_s) begin
            idx_r        <= '0;
            hit_r        <= 1'b0;
            free_found_r <= 1'b0;
            op_succ_r    <= 1'b0;
            value_r      <= '0;
         end else if (state_r == ST_SEARCH) begin
            idx_r        <= last_s ? '0 : idx_r + IDX_W'(1);
            hit_r        <= hit_s;
            hit_idx_r    <= hit_idx_s;
            hit_value_r  <= hit_value_s;
            free_found_r <= free_found_s;
            free_idx_r   <= free_idx_s;
            if (commit_s) begin
               op_succ_r <= succ_s;
               value_r   <= result_s;
            end
         end
      end
   end
endmodule

// File: tb/tb_kv_cache_controller.sv
// Directed bench for kv_cache_controller with a four-slot table.
module tb_kv_cache_controller;
   import ctrl_types_pkg::*;

   localparam int N = 4;

   logic        clk;
   logic        rst_n;
   operation_e  operation_in;
   logic [31:0] key_in;
   logic [31:0] value_in;
   logic        ready_out;
   logic        op_succ_out;
   logic [31:0] value_out;
   logic [2:0]  count_out;

   int checks = 0;
   int errors = 0;

   kv_cache_controller #(.NUM_ENTRIES(N)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .operation_in (operation_in),
      .key_in       (key_in),
      .value_in     (value_in),
      .ready_out    (ready_out),
      .op_succ_out  (op_succ_out),
      .value_out    (value_out),
      .count_out    (count_out)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", tag, act, exp);
      end
   endtask

   // Present one operation, wait for the ready pulse and check the result.
   task automatic run_op(input string tag, input operation_e op, input logic [31:0] k,
                         input logic [31:0] v, input logic succ, input logic [31:0] val,
                         input int cnt, input bit hold);
      int lat;
      @(negedge clk);
      operation_in = op;
      key_in       = k;
      value_in     = v;
      lat = 0;
      while (!ready_out && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check({tag, "_lat"}, 64'(lat - 1), 64'(N + 1));
      check({tag, "_succ"}, 64'(op_succ_out), 64'(succ));
      check({tag, "_val"}, 64'(value_out), 64'(val));
      check({tag, "_cnt"}, 64'(count_out), 64'(cnt));
      if (!hold) begin
         operation_in = NOOP;
         @(negedge clk);
         check({tag, "_rdy_low"}, 64'(ready_out), 64'd0);
      end
   endtask

   initial begin
      int pulses;
      rst_n        = 1'b0;
      operation_in = NOOP;
      key_in       = 32'd0;
      value_in     = 32'd0;
      repeat (3) @(negedge clk);
      check("rst_rdy", 64'(ready_out), 64'd0);
      check("rst_succ", 64'(op_succ_out), 64'd0);
      check("rst_val", 64'(value_out), 64'd0);
      check("rst_cnt", 64'(count_out), 64'd0);
      rst_n = 1'b1;

      run_op("rd_empty", READ,   32'h11, 32'h0,         1'b0, 32'h0,         0, 1'b0);
      run_op("up_11",    UPSERT, 32'h11, 32'hDEAD_BEEF, 1'b1, 32'hDEAD_BEEF, 1, 1'b0);
      run_op("rd_11",    READ,   32'h11, 32'h0,         1'b1, 32'hDEAD_BEEF, 1, 1'b0);
      run_op("ow_11",    UPSERT, 32'h11, 32'h1234,      1'b1, 32'h1234,      1, 1'b0);
      run_op("rd_11b",   READ,   32'h11, 32'h0,         1'b1, 32'h1234,      1, 1'b0);
      run_op("del_11",   DELETE, 32'h11, 32'h0,         1'b1, 32'h1234,      0, 1'b0);

      for (int k = 1; k <= 4; k++) begin
         run_op("fill", UPSERT, 32'(k), 32'h100 + 32'(k), 1'b1, 32'h100 + 32'(k), k, 1'b0);
      end
      run_op("up_full",  UPSERT, 32'h5, 32'h105, 1'b0, 32'h105, 4, 1'b0);
      run_op("rd_5miss", READ,   32'h5, 32'h0,   1'b0, 32'h0,   4, 1'b0);
      run_op("del_2",    DELETE, 32'h2, 32'h0,   1'b1, 32'h102, 3, 1'b0);
      run_op("up_5",     UPSERT, 32'h5, 32'h555, 1'b1, 32'h555, 4, 1'b0);
      check("slot1_key", 64'(dut.u_store.key_r[1]), 64'h5);

      // Hold READ after the response: no further pulse until NOOP is seen.
      run_op("rd_5hold", READ, 32'h5, 32'h0, 1'b1, 32'h555, 4, 1'b1);
      pulses = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (ready_out) pulses++;
      end
      check("hold_pulses", 64'(pulses), 64'd0);
      check("hold_succ", 64'(op_succ_out), 64'd1);
      operation_in = NOOP;
      @(negedge clk);

      run_op("del_3",  DELETE, 32'h3, 32'h0,  1'b1, 32'h103, 3, 1'b0);
      run_op("up_k0",  UPSERT, 32'h0, 32'hAB, 1'b1, 32'hAB,  4, 1'b0);
      run_op("rd_k0",  READ,   32'h0, 32'h0,  1'b1, 32'hAB,  4, 1'b0);

      // Reset in the middle of a search aborts the insert.
      @(negedge clk);
      operation_in = UPSERT;
      key_in       = 32'h7;
      value_in     = 32'h777;
      repeat (3) @(negedge clk);
      check("mid_state", 64'(dut.state_r), 64'(ST_SEARCH));
      rst_n = 1'b0;
      #1;
      check("mid_rst_rdy", 64'(ready_out), 64'd0);
      check("mid_rst_succ", 64'(op_succ_out), 64'd0);
      check("mid_rst_val", 64'(value_out), 64'd0);
      check("mid_rst_cnt", 64'(count_out), 64'd0);
      operation_in = NOOP;
      @(negedge clk);
      rst_n = 1'b1;
      run_op("rd_7", READ, 32'h7, 32'h0, 1'b0, 32'h0, 0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
